sprite_blitter: RTL

- Drives a sprite_ram_module instance and forwards its pixels to the VGA frame-buffer write port.
- On a start pulse it scans every sprite address and compensates the one-cycle RAM read latency.
- Adds the screen origin to each pixel, drops transparent and off-screen pixels, and issues one write-enable per visible pixel.
- Sits between the game-logic FSM (which issues start/origin) and the VGA adapter. It replaces the bare plotter for sprite drawing.

---
 rtl/sprite_blitter_if.sv | 31 +++
 rtl/sprite_blitter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request/status, sprite RAM read port and
// frame-buffer write port, grouped for the blitter and its environment.
interface sprite_blitter_if #(
    parameter int SPR_WX = 4,
    parameter int SPR_WY = 3,
    parameter int SCR_WX = 8,
    parameter int SCR_WY = 7
);
    logic              start;
    logic [SCR_WX-1:0] origin_x;
    logic [SCR_WY-1:0] origin_y;
    logic [SPR_WX-1:0] spr_x;
    logic [SPR_WY-1:0] spr_y;
    logic [2:0]        ram_color;
    logic [SCR_WX-1:0] vga_x;
    logic [SCR_WY-1:0] vga_y;
    logic [2:0]        vga_color;
    logic              vga_plot;
    logic              busy;
    logic              done;

    modport slave (
        input  start, origin_x, origin_y, ram_color,
        output spr_x, spr_y, vga_x, vga_y, vga_color, vga_plot, busy, done
    );

    modport master (
        output start, origin_x, origin_y, ram_color,
        input  spr_x, spr_y, vga_x, vga_y, vga_color, vga_plot, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Scans a sprite RAM in raster order, offsets each pixel by the latched
// origin and writes visible, on-screen pixels to the frame buffer.
module sprite_blitter #(
    parameter int         SPR_WX      = 4,
    parameter int         SPR_WY      = 3,
    parameter int         SPRITE_W    = 10,
    parameter int         SPRITE_H    = 6,
    parameter int         SCR_WX      = 8,
    parameter int         SCR_WY      = 7,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input logic             clk,
    input logic             reset,
    sprite_blitter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [SPR_WX-1:0] x_q;
    logic [SPR_WY-1:0] y_q;
    logic              last_x;
    logic              last_addr;

    logic [SCR_WX-1:0] ox_q;
    logic [SCR_WY-1:0] oy_q;

    logic              v1_q;
    logic [SPR_WX-1:0] ax1_q;
    logic [SPR_WY-1:0] ay1_q;

    logic [SCR_WX:0]   sx;
    logic [SCR_WY:0]   sy;
    logic              visible;

    logic [SCR_WX-1:0] vga_x_q;
    logic [SCR_WY-1:0] vga_y_q;
    logic [2:0]        vga_color_q;
    logic              vga_plot_q;

    logic              busy_c;
    logic              done_c;

    assign last_x    = (x_q == SPR_WX'(SPRITE_W - 1));
    assign last_addr = last_x && (y_q == SPR_WY'(SPRITE_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (last_addr) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            IDLE:    busy_c = 1'b0;
            SCAN:    busy_c = 1'b1;
            DRAIN:   busy_c = 1'b1;
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: busy_c = 1'b0;
        endcase
    end

    // Address is zero outside SCAN, so (0,0) is already presented on entry.
    always_ff @(posedge clk) begin
        if (reset || state != SCAN) begin
            x_q <= '0;
            y_q <= '0;
        end else if (last_x) begin
            x_q <= '0;
            y_q <= last_addr ? '0 : y_q + 1'b1;
        end else begin
            x_q <= x_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ox_q <= '0;
            oy_q <= '0;
        end else if (state == IDLE && bus.start) begin
            ox_q <= bus.origin_x;
            oy_q <= bus.origin_y;
        end
    end

    // Stage 1 travels alongside the RAM read so it lines up with ram_color.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            ax1_q <= '0;
            ay1_q <= '0;
        end else begin
            v1_q  <= (state == SCAN);
            ax1_q <= x_q;
            ay1_q <= y_q;
        end
    end

    // One extra bit so off-screen sums are clipped rather than wrapped.
    always_comb begin
        sx      = (SCR_WX + 1)'(ox_q) + (SCR_WX + 1)'(ax1_q);
        sy      = (SCR_WY + 1)'(oy_q) + (SCR_WY + 1)'(ay1_q);
        visible = v1_q
                  && (bus.ram_color != TRANSPARENT)
                  && (sx < (SCR_WX + 1)'(SCREEN_W))
                  && (sy < (SCR_WY + 1)'(SCREEN_H));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_plot_q  <= 1'b0;
        end else begin
            vga_x_q     <= sx[SCR_WX-1:0];
            vga_y_q     <= sy[SCR_WY-1:0];
            vga_color_q <= bus.ram_color;
            vga_plot_q  <= visible;
        end
    end

    assign bus.spr_x     = x_q;
    assign bus.spr_y     = y_q;
    assign bus.vga_x     = vga_x_q;
    assign bus.vga_y     = vga_y_q;
    assign bus.vga_color = vga_color_q;
    assign bus.vga_plot  = vga_plot_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;

endmodule
